// File: rtl/ahb_cmd_master.sv
// Command-to-AHB-lite single-transfer master with a two-stage address/data
// pipeline and two-cycle ERROR handling that replays the pending address phase.
module ahb_cmd_master (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HRESP
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  logic        a_valid_q, a_valid_d;
  logic [31:0] a_addr_q, a_addr_d;
  logic [1:0]  a_size_q, a_size_d;
  logic        a_write_q, a_write_d;
  logic [31:0] a_wdata_q, a_wdata_d;
  logic        d_valid_q, d_valid_d;
  logic        d_write_q, d_write_d;
  logic [31:0] d_wdata_q, d_wdata_d;
  logic        err_hold_q, err_hold_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_write_q, rsp_write_d;
  logic        rsp_error_q, rsp_error_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        accept;
  logic [1:0]  cmd_size_eff;

  assign cmd_ready    = (!a_valid_q || HREADY) && !err_hold_q && !HRESET;
  assign accept       = cmd_valid && cmd_ready;
  // Illegal size 3 is folded onto word transfers.
  assign cmd_size_eff = (cmd_size == 2'd3) ? 2'd2 : cmd_size;

  assign HTRANS    = (a_valid_q && !err_hold_q) ? TRANS_NONSEQ : TRANS_IDLE;
  assign HADDR     = a_addr_q;
  assign HSIZE     = {1'b0, a_size_q};
  assign HWRITE    = a_write_q;
  assign HWDATA    = d_wdata_q;
  assign busy      = a_valid_q || d_valid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;

  always_comb begin
    a_valid_d   = a_valid_q;
    a_addr_d    = a_addr_q;
    a_size_d    = a_size_q;
    a_write_d   = a_write_q;
    a_wdata_d   = a_wdata_q;
    d_valid_d   = d_valid_q;
    d_write_d   = d_write_q;
    d_wdata_d   = d_wdata_q;
    err_hold_d  = err_hold_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_rdata_d = 32'h0;

    if (d_valid_q && HREADY) begin
      rsp_valid_d = 1'b1;
      rsp_write_d = d_write_q;
      rsp_error_d = HRESP;
      rsp_rdata_d = (!d_write_q && !HRESP) ? HRDATA : 32'h0;
    end

    if (HREADY) begin
      if (err_hold_q) begin
        // End of the ERROR response: retire the data phase, keep the
        // cancelled address phase so it is reissued next cycle.
        d_valid_d  = 1'b0;
        err_hold_d = 1'b0;
      end else begin
        d_valid_d = a_valid_q;
        d_write_d = a_write_q;
        d_wdata_d = a_wdata_q;
        a_valid_d = accept;
        if (accept) begin
          a_addr_d  = cmd_addr;
          a_size_d  = cmd_size_eff;
          a_write_d = cmd_write;
          a_wdata_d = cmd_wdata;
        end
      end
    end else begin
      if (accept) begin
        a_valid_d = 1'b1;
        a_addr_d  = cmd_addr;
        a_size_d  = cmd_size_eff;
        a_write_d = cmd_write;
        a_wdata_d = cmd_wdata;
      end
      if (d_valid_q && HRESP && !err_hold_q) begin
        err_hold_d = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      a_valid_q   <= 1'b0;
      a_addr_q    <= 32'h0;
      a_size_q    <= 2'd0;
      a_write_q   <= 1'b0;
      a_wdata_q   <= 32'h0;
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      d_wdata_q   <= 32'h0;
      err_hold_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_addr_q    <= a_addr_d;
      a_size_q    <= a_size_d;
      a_write_q   <= a_write_d;
      a_wdata_q   <= a_wdata_d;
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      d_wdata_q   <= d_wdata_d;
      err_hold_q  <= err_hold_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed bench for ahb_cmd_master: bus-side checks in the stimulus thread,
// response checks by a scoreboard monitor fed from an expected-response queue.
module tb_ahb_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

  typedef struct packed {
    logic        write;
    logic [31:0] rdata;
    logic        error;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  ahb_cmd_master dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .busy(busy),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
      $display("check %-22s act=%08h exp=%08h ok", name, act, exp);
    end else begin
      $display("FAIL %s act=%08h exp=%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic offer(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                       input logic [31:0] wd);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = sz;
    cmd_wdata = wd;
  endtask

  task automatic expect_rsp(input logic wr, input logic [31:0] rd, input logic err);
    rsp_t r;
    r.write = wr;
    r.rdata = rd;
    r.error = err;
    exp_q.push_back(r);
  endtask

  // Scoreboard monitor: every response pulse must match the oldest expectation.
  always @(negedge HCLK) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_rsp act=write:%0d rdata:%08h error:%0d exp=none",
                 rsp_write, rsp_rdata, rsp_error);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        checks++;
        if (rsp_write === e.write && rsp_rdata === e.rdata && rsp_error === e.error) begin
          passes++;
          $display("rsp   write=%0d rdata=%08h error=%0d ok", rsp_write, rsp_rdata, rsp_error);
        end else begin
          $display("FAIL rsp act=write:%0d rdata:%08h error:%0d exp=write:%0d rdata:%08h error:%0d",
                   rsp_write, rsp_rdata, rsp_error, e.write, e.rdata, e.error);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
    cmd_size = 2'd0; cmd_wdata = 32'h0; HREADY = 1'b1; HRDATA = 32'h0; HRESP = 1'b0;
    tick(); tick();
    chk("reset_htrans", {30'h0, HTRANS}, 32'h0);
    chk("reset_haddr", HADDR, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_ready", {31'h0, cmd_ready}, 32'h0);
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    HRESET = 1'b0;
    #1;
    chk("ready_after_reset", {31'h0, cmd_ready}, 32'h1);

    // Single write, zero wait states
    offer(1'b1, 32'h1000, 2'd2, 32'hA5A5A5A5);
    expect_rsp(1'b1, 32'h0, 1'b0);
    tick();
    cmd_valid = 1'b0;
    chk("wr_htrans", {30'h0, HTRANS}, 32'h2);
    chk("wr_haddr", HADDR, 32'h1000);
    chk("wr_hwrite", {31'h0, HWRITE}, 32'h1);
    chk("wr_hsize", {29'h0, HSIZE}, 32'h2);
    tick();
    chk("wr_idle_after", {30'h0, HTRANS}, 32'h0);
    chk("wr_hwdata", HWDATA, 32'hA5A5A5A5);
    tick();
    chk("wr_latency", {31'h0, rsp_valid}, 32'h1);
    tick();

    // Pipelined reads
    offer(1'b0, 32'h0, 2'd2, 32'h0);
    expect_rsp(1'b0, 32'h11, 1'b0);
    expect_rsp(1'b0, 32'h22, 1'b0);
    expect_rsp(1'b0, 32'h33, 1'b0);
    tick();
    offer(1'b0, 32'h4, 2'd2, 32'h0);
    chk("pipe_a0", HADDR, 32'h0);
    tick();
    offer(1'b0, 32'h8, 2'd2, 32'h0);
    HRDATA = 32'h11;
    chk("pipe_a4", HADDR, 32'h4);
    chk("pipe_a4_trans", {30'h0, HTRANS}, 32'h2);
    tick();
    cmd_valid = 1'b0;
    HRDATA = 32'h22;
    chk("pipe_a8", HADDR, 32'h8);
    chk("pipe_a8_trans", {30'h0, HTRANS}, 32'h2);
    tick();
    HRDATA = 32'h33;
    chk("pipe_idle", {30'h0, HTRANS}, 32'h0);
    tick(); tick();

    // Wait states with a second command queued in the address phase
    offer(1'b0, 32'h20, 2'd2, 32'h0);
    expect_rsp(1'b0, 32'h5555AAAA, 1'b0);
    expect_rsp(1'b1, 32'h0, 1'b0);
    tick();
    offer(1'b1, 32'h24, 2'd2, 32'hDEADBEEF);
    tick();
    cmd_valid = 1'b0;
    HREADY = 1'b0;
    HRDATA = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wait_haddr", HADDR, 32'h24);
      chk("wait_htrans", {30'h0, HTRANS}, 32'h2);
      chk("wait_ready", {31'h0, cmd_ready}, 32'h0);
      tick();
    end
    HREADY = 1'b1;
    HRDATA = 32'h5555AAAA;
    chk("wait_end_haddr", HADDR, 32'h24);
    tick();
    chk("wait_hwdata", HWDATA, 32'hDEADBEEF);
    tick(); tick();

    // Two-cycle ERROR on a write with a read pending behind it
    offer(1'b1, 32'h40, 2'd2, 32'h12345678);
    expect_rsp(1'b1, 32'h0, 1'b1);
    expect_rsp(1'b0, 32'h44444444, 1'b0);
    tick();
    offer(1'b0, 32'h44, 2'd2, 32'h0);
    tick();
    cmd_valid = 1'b0;
    HREADY = 1'b0;
    HRESP = 1'b1;
    #1;
    chk("err1_htrans", {30'h0, HTRANS}, 32'h2);
    chk("err1_haddr", HADDR, 32'h44);
    tick();
    HREADY = 1'b1;
    chk("err2_htrans_idle", {30'h0, HTRANS}, 32'h0);
    chk("err2_ready", {31'h0, cmd_ready}, 32'h0);
    tick();
    HRESP = 1'b0;
    chk("reissue_htrans", {30'h0, HTRANS}, 32'h2);
    chk("reissue_haddr", HADDR, 32'h44);
    tick();
    HRDATA = 32'h44444444;
    chk("reissue_done", {30'h0, HTRANS}, 32'h0);
    tick(); tick();

    // ERROR with HREADY high and no first error cycle
    offer(1'b0, 32'h50, 2'd2, 32'h0);
    expect_rsp(1'b0, 32'h0, 1'b1);
    tick();
    cmd_valid = 1'b0;
    tick();
    HRESP = 1'b1;
    HRDATA = 32'h77777777;
    tick();
    HRESP = 1'b0;
    tick();

    // Illegal size 3 issued as word
    offer(1'b0, 32'h60, 2'd3, 32'h0);
    expect_rsp(1'b0, 32'h66, 1'b0);
    tick();
    cmd_valid = 1'b0;
    chk("size3_hsize", {29'h0, HSIZE}, 32'h2);
    tick();
    HRDATA = 32'h66;
    tick(); tick();

    // Reset during a waited data phase
    offer(1'b0, 32'h80, 2'd2, 32'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    HREADY = 1'b0;
    #1;
    chk("rst_pre_busy", {31'h0, busy}, 32'h1);
    HRESET = 1'b1;
    #1;
    chk("rst_ready_low", {31'h0, cmd_ready}, 32'h0);
    tick();
    HRESET = 1'b0;
    HREADY = 1'b1;
    chk("rst_htrans", {30'h0, HTRANS}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_no_rsp", {31'h0, rsp_valid}, 32'h0);
    offer(1'b1, 32'h90, 2'd2, 32'h0F0F0F0F);
    expect_rsp(1'b1, 32'h0, 1'b0);
    tick();
    cmd_valid = 1'b0;
    chk("post_rst_haddr", HADDR, 32'h90);
    tick();
    chk("post_rst_hwdata", HWDATA, 32'h0F0F0F0F);
    tick(); tick(); tick();

    chk("scoreboard_empty", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ahb_cmd_master.md
AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

Interface
REQ-001 SHALL have no parameters; address and data widths are fixed at 32 bits.
REQ-002 SHALL have ports:
- HCLK  in  1  sole clock; all state updates on rising edge
- HRESET  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at an edge
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  32  byte address; caller guarantees alignment to cmd_size
- cmd_size  in  2  0=byte, 1=half, 2=word; 3 is illegal
- cmd_wdata  in  32  write data; caller places bytes on the correct lanes
- rsp_valid  out  1  one-cycle completion pulse; no backpressure
- rsp_write  out  1  direction of the completed transfer
- rsp_rdata  out  32  HRDATA captured on reads, 0 on writes
- rsp_error  out  1  transfer ended with an ERROR response
- busy  out  1  any transfer in address or data phase
- HADDR  out  32;  HTRANS  out  2;  HSIZE  out  3;  HWRITE  out  1;  HWDATA  out  32
- HREADY  in  1;  HRDATA  in  32;  HRESP  in  1 (AHB-lite: 0=OKAY, 1=ERROR)

Function
REQ-003 SHALL hold an address-phase register (a_valid, addr, size, write, wdata) and a data-phase register (d_valid, write, wdata).
REQ-004 SHALL drive HTRANS=NONSEQ (2'b10) when a_valid && !err_hold, else IDLE (2'b00); HADDR/HSIZE/HWRITE come from the address-phase register; HSIZE={1'b0,size}.
REQ-005 SHALL drive HWDATA from the data-phase wdata, held stable for the whole data phase including wait states.
REQ-006 SHALL compute cmd_ready = (!a_valid || HREADY) && !err_hold && !HRESET, combinationally.
REQ-007 At an edge with HREADY=1 and !err_hold: the data-phase register SHALL load from the address-phase register (d_valid<=a_valid); the address-phase register SHALL load the accepted command, or clear a_valid if none.
REQ-008 At an edge with HREADY=0: a_valid=0 with an accepted command SHALL load the address register; otherwise address and data registers SHALL hold.
REQ-009 Transfers SHALL be single NONSEQ only; HTRANS SHALL never be BUSY or SEQ.
REQ-010 Back-to-back commands SHALL pipeline: the address phase of N+1 overlaps the data phase of N, giving one transfer per cycle at zero wait states.
REQ-011 Data phase completion SHALL occur at an edge with d_valid && HREADY. In the following cycle: rsp_valid=1; rsp_write=d.write; rsp_error=HRESP as sampled; rsp_rdata=HRDATA for an OKAY read, else 0.
REQ-012 Latency: a command accepted at edge E with zero wait states SHALL give rsp_valid high in the cycle after edge E+2.
REQ-013 First ERROR cycle (d_valid && HRESP && !HREADY at an edge) SHALL set err_hold, forcing HTRANS=IDLE during the second error cycle.
REQ-014 At the edge ending the second error cycle (HREADY=1): the errored transfer completes per REQ-011 with rsp_error=1; d_valid<=0; the pending address-phase command SHALL be retained, not advanced, then reissued as NONSEQ in the next cycle; err_hold clears.
REQ-015 HRESP=1 sampled together with HREADY=1 without a preceding first error cycle SHALL still complete the transfer with rsp_error=1 (tolerant of protocol violations).
REQ-016 busy SHALL equal a_valid || d_valid.
REQ-017 cmd_size=3 SHALL be treated as size 2.

Reset
REQ-018 When HRESET=1 at an edge: a_valid, d_valid, err_hold, rsp_valid, rsp_write, rsp_error SHALL be 0; rsp_rdata=0; address/data registers=0. Outputs then read HTRANS=IDLE, HADDR=0, HSIZE=0, HWRITE=0, HWDATA=0, busy=0.
REQ-019 Reset mid-transfer SHALL abandon in-flight transfers with no response generated; cmd_ready SHALL be 0 while HRESET=1.

Verification
REQ-020 Single write, zero wait: cmd write addr=0x1000 data=0xA5A5A5A5 size=2 -> HTRANS=NONSEQ, HADDR=0x1000 for 1 cycle; HWDATA=0xA5A5A5A5 next cycle; rsp_valid=1, rsp_error=0 one cycle later.
REQ-021 Pipelined reads 0x0, 0x4, 0x8 on consecutive cycles, HRDATA=0x11,0x22,0x33 -> three consecutive NONSEQ cycles; three consecutive rsp_valid pulses in order with rsp_rdata 0x11,0x22,0x33.
REQ-022 Wait states: read 0x20 with HREADY low 3 cycles while a second command is offered -> HADDR/HTRANS of the second held stable, cmd_ready=0 during waits; rsp_valid once after HREADY returns.
REQ-023 Error: write 0x40 then read 0x44 back-to-back; slave returns 2-cycle ERROR on 0x40 -> HTRANS=IDLE in the second error cycle; rsp_error=1 for 0x40; read 0x44 reissued as NONSEQ next cycle and completes OKAY.
REQ-024 Reset during a waited data phase -> next cycle HTRANS=IDLE, busy=0, no rsp_valid; a new command after reset deasserts completes normally.
